// File: rtl/counter_dec_pkg.sv
// rtl/counter_dec_pkg.sv - BCD digit type, digit bounds and load clamp
package counter_dec_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/counter_dec_nw_if.sv
// rtl/counter_dec_nw_if.sv - command/status bundle of the BCD up/down counter
interface counter_dec_nw_if #(
    parameter int DIGITS = 4
);
    import counter_dec_pkg::*;

    logic                    i_load;
    bcd_digit_t [DIGITS-1:0] i_count;
    logic                    i_plus;
    logic                    i_minus;
    bcd_digit_t [DIGITS-1:0] o_count;
    logic                    o_plus;
    logic                    o_minus;
    logic                    o_zero;
    logic                    o_max;

    modport master (
        output i_load, i_count, i_plus, i_minus,
        input  o_count, o_plus, o_minus, o_zero, o_max
    );

    modport slave (
        input  i_load, i_count, i_plus, i_minus,
        output o_count, o_plus, o_minus, o_zero, o_max
    );

endinterface

// File: rtl/counter_dec_cell.sv
// rtl/counter_dec_cell.sv - one BCD digit with load, step up/down and carry/borrow out
module counter_dec_cell
    import counter_dec_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  bcd_digit_t load_val,
    input  logic       inc,
    input  logic       dec,
    output bcd_digit_t q,
    output logic       carry,
    output logic       borrow
);

    // carry/borrow are combinational so a whole chain settles in one cycle
    assign carry  = inc && (q == BCD_MAX);
    assign borrow = dec && (q == BCD_MIN);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= BCD_MIN;
        end else if (load) begin
            q <= bcd_clamp(load_val);
        end else if (inc) begin
            q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
        end else if (dec) begin
            q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
        end
    end

endmodule

// File: rtl/counter_dec_nw.sv
// rtl/counter_dec_nw.sv - DIGITS-wide BCD up/down counter with wrap or saturate boundaries
module counter_dec_nw
    import counter_dec_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SATURATE = 0
) (
    input  logic           i_clk,
    input  logic           i_rst,
    counter_dec_nw_if.slave bus
);

    logic                    sat;
    logic                    cmd_inc;
    logic                    cmd_dec;
    logic                    inc0;
    logic                    dec0;
    logic                    ovf;
    logic                    unf;
    logic                    all_nine;
    logic                    all_zero;
    logic                    plus_q;
    logic                    minus_q;
    bcd_digit_t [DIGITS-1:0] count;

    assign sat     = (SATURATE != 0);
    assign cmd_inc = bus.i_plus & ~bus.i_minus & ~bus.i_load;
    assign cmd_dec = bus.i_minus & ~bus.i_plus & ~bus.i_load;

    // saturation simply withholds the step from the chain at the boundary
    assign inc0 = cmd_inc & ~(sat & all_nine);
    assign dec0 = cmd_dec & ~(sat & all_zero);

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic inc;
        logic dec;
        logic cy;
        logic bw;

        if (g == 0) begin : g_lsd
            assign inc = inc0;
            assign dec = dec0;
        end else begin : g_upper
            assign inc = g_digit[g-1].cy;
            assign dec = g_digit[g-1].bw;
        end

        counter_dec_cell u_cell (
            .clk      (i_clk),
            .rst      (i_rst),
            .load     (bus.i_load),
            .load_val (bus.i_count[g]),
            .inc      (inc),
            .dec      (dec),
            .q        (count[g]),
            .carry    (cy),
            .borrow   (bw)
        );
    end

    assign ovf = sat ? (cmd_inc & all_nine) : g_digit[DIGITS-1].cy;
    assign unf = sat ? (cmd_dec & all_zero) : g_digit[DIGITS-1].bw;

    always_comb begin
        all_nine = 1'b1;
        all_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (count[i] != BCD_MAX) all_nine = 1'b0;
            if (count[i] != BCD_MIN) all_zero = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            plus_q  <= 1'b0;
            minus_q <= 1'b0;
        end else begin
            plus_q  <= ovf;
            minus_q <= unf;
        end
    end

    assign bus.o_count = count;
    assign bus.o_plus  = plus_q;
    assign bus.o_minus = minus_q;
    assign bus.o_zero  = all_zero;
    assign bus.o_max   = all_nine;

endmodule
